// File: rtl/imm_pkg.sv
// Shared types, field positions and the sign-extension helper for the
// immediate-extension arbiter.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_D  = 3'd1,
    FMT_B  = 3'd2,
    FMT_CB = 3'd3,
    FMT_IW = 3'd4
  } imm_fmt_e;

  typedef enum logic {
    O_EMPTY = 1'b0,
    O_FULL  = 1'b1
  } ostate_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int I_LSB     = 10;
  localparam int I_W       = 12;
  localparam int D_LSB     = 12;
  localparam int D_W       = 9;
  localparam int B_LSB     = 0;
  localparam int B_W       = 26;
  localparam int CB_LSB    = 5;
  localparam int CB_W      = 19;
  localparam int IW_LSB    = 5;
  localparam int IW_W      = 16;
  localparam int IW_SH_LSB = 21;

  // Sign-extends the low 'width' bits of val to 64 bits.
  function automatic logic [63:0] sext64(input logic [63:0] val, input int unsigned width);
    logic [63:0] mask;
    logic [5:0]  msb;
    mask = ~64'd0 << width;
    msb  = 6'(width - 1);
    return val[msb] ? (val | mask) : (val & ~mask);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extractor: picks the field for the format code,
// then sign/zero-extends and shifts it to 64 bits.
module imm_extend
  import imm_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  fmt,
  output logic [63:0] imm,
  output logic        err
);

  logic [5:0] iw_shift;
  logic       unused_hi;

  assign iw_shift  = {instr[IW_SH_LSB +: 2], 4'b0000};
  assign unused_hi = ^instr[31:26];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (fmt)
      FMT_I:   imm = 64'(instr[I_LSB +: I_W]);
      FMT_D:   imm = sext64(64'(instr[D_LSB +: D_W]), D_W);
      FMT_B:   imm = sext64(64'(instr[B_LSB +: B_W]), B_W) << 2;
      FMT_CB:  imm = sext64(64'(instr[CB_LSB +: CB_W]), CB_W) << 2;
      FMT_IW:  imm = 64'(instr[IW_LSB +: IW_W]) << iw_shift;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_arbiter.sv
// Round-robin arbiter sharing one immediate extender between two requesters,
// with a single-entry valid/ready output register and per-requester grant counters.
//
// state   | meaning
// O_EMPTY | output register holds nothing; any request may be granted
// O_FULL  | output register holds a result awaiting out_ready
module imm_extend_arbiter
  import imm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [31:0]       a_instr,
  input  logic [2:0]        a_fmt,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [31:0]       b_instr,
  input  logic [2:0]        b_fmt,
  output logic              b_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_src,
  output logic              out_err,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt
);

  ostate_e           state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              src_q, src_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;

  logic        grant_ok;
  logic        pick_b;
  logic        grant;
  logic [31:0] sel_instr;
  logic [2:0]  sel_fmt;
  logic [63:0] ext_imm;
  logic        ext_err;

  // Draining slot may be refilled in the same cycle (pass-through on out_ready).
  assign grant_ok  = (state_q == O_EMPTY) || out_ready;
  assign pick_b    = b_valid && (!a_valid || (last_q == SRC_A));
  assign a_ready   = grant_ok && a_valid && !pick_b;
  assign b_ready   = grant_ok && pick_b;
  assign grant     = a_ready || b_ready;
  assign sel_instr = pick_b ? b_instr : a_instr;
  assign sel_fmt   = pick_b ? b_fmt : a_fmt;

  imm_extend u_ext (
    .instr (sel_instr),
    .fmt   (sel_fmt),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    imm_d   = imm_q;
    src_d   = src_q;
    err_d   = err_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;

    case (state_q)
      O_EMPTY: if (grant) state_d = O_FULL;
      O_FULL:  if (out_ready && !grant) state_d = O_EMPTY;
      default: state_d = O_EMPTY;
    endcase

    if (grant) begin
      last_d = pick_b;
      imm_d  = ext_imm;
      src_d  = pick_b;
      err_d  = ext_err;
    end

    if (a_ready && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + 1'b1;
    if (b_ready && (b_cnt_q != '1)) b_cnt_d = b_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= O_EMPTY;
      last_q  <= SRC_B;
      imm_q   <= '0;
      src_q   <= 1'b0;
      err_q   <= 1'b0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      imm_q   <= imm_d;
      src_q   <= src_d;
      err_q   <= err_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign out_valid = (state_q == O_FULL);
  assign out_imm   = imm_q;
  assign out_src   = src_q;
  assign out_err   = err_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;

endmodule

// File: doc/imm_extend_arbiter.md
# imm_extend_arbiter

Shares one immediate-extension datapath between the decode stage (requester A) and the branch-target unit (requester B) of the 64-bit core. Each cycle at most one request is granted round-robin. The granted instruction's immediate field is selected by format, then sign- or zero-extended and shifted to 64 bits. The result is held in a single-entry output register with a valid/ready handshake.

## Interface
- `DATA_W`, 64, output immediate width; fixed at 64.
- `CNT_W`, 16, width of the per-requester saturating grant counters.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `a_valid`  in  1  requester A has a request.
- `a_instr`  in  32  requester A instruction word.
- `a_fmt`  in  3  requester A format code.
- `a_ready`  out  1  A's request accepted this cycle.
- `b_valid`, `b_instr`, `b_fmt`, `b_ready`: same as the A signals, for requester B.
- `out_valid`  out  1  result register full.
- `out_ready`  in  1  consumer accepts result.
- `out_imm`  out  64  extended immediate.
- `out_src`  out  1  requester that owns the result: 0 = A, 1 = B.
- `out_err`  out  1  format code was illegal.
- `a_cnt`, `b_cnt`  out  CNT_W  number of grants per requester; saturating.

## Operation
**Format decode:**
- fmt 0 (I): `instr[21:10]`, zero-extended.
- fmt 1 (D): `instr[20:12]`, sign-extended.
- fmt 2 (B): `instr[25:0]`, sign-extended, then shifted left by 2.
- fmt 3 (CB): `instr[23:5]`, sign-extended, then shifted left by 2.
- fmt 4 (IW): `instr[20:5]`, zero-extended, then shifted left by `16*instr[22:21]`.
- fmt 5–7: `out_imm` = 0 and `out_err` = 1.

**Output-stage FSM:**
- EMPTY → FULL on a grant.
- FULL → FULL on a drain (`out_valid & out_ready`) with a simultaneous grant.
- FULL → EMPTY on a drain with no grant.
- FULL stays FULL while `out_ready` = 0.

**Grant rules:**
- A grant is allowed when the stage is EMPTY or draining this cycle.
- If only one requester is valid, it wins.
- If both are valid, the requester not granted last wins.
- `last_grant` updates only on a grant.

**Handshake and counters:**
- `a_ready` / `b_ready` are combinational from the valids, the FSM state and `out_ready`. They are one-hot or both 0.
- A request is accepted only when `x_valid & x_ready`.
- Requesters hold their instr/fmt stable until accepted.
- A requester's counter increments on each of its grants and saturates at all-ones.

**Reset values:**
- `out_valid` = 0, `out_imm` = 0, `out_src` = 0, `out_err` = 0.
- `last_grant` = B, so A wins the first tie.
- Both counters = 0.

**Reset mid-operation:** a held result is discarded and no stale `out_valid` appears after reset release.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on `out_*` with `out_valid` = 1 after edge N.
- Throughput is 1 result per cycle when `out_ready` is held at 1.
- `out_*` is stable while `out_valid & !out_ready`.
- There is no combinational path from `a_instr` / `b_instr` to the outputs. Ready depends on `out_ready` (pass-through drain).
- The extender logic is purely combinational between the grant mux and the output register.

## Structure
- Package `imm_pkg`:
  - `imm_fmt_e` enum: `FMT_I`=0, `FMT_D`, `FMT_B`, `FMT_CB`, `FMT_IW`.
  - Field-position localparams.
  - FSM state enum `ostate_e`: `O_EMPTY`, `O_FULL`.
- Sub-module `imm_extend` (combinational): inputs `instr` and `fmt`; outputs `imm[63:0]` and `err`. It uses a width-parameterized sign-extension function.
- Top level contains the arbiter, the FSM, the output register and the counters.

## Test plan
- **Field extraction and extension:** A only, `out_ready` = 1. Expected `out_imm` one cycle after each request, `out_src` = 0:
  - fmt D, `instr[20:12]` = 9'h1FF → 64'hFFFF_FFFF_FFFF_FFFF.
  - fmt I, `instr[21:10]` = 12'hFFF → 64'h0000_0000_0000_0FFF.
  - fmt B, `instr[25:0]` = 26'h3FF_FFFF → 64'hFFFF_FFFF_FFFF_FFFC.
  - fmt CB, `instr[23:5]` = 19'h10 → 64'h40.
  - fmt IW, `instr[20:5]` = 16'h1234, `instr[22:21]` = 2 → 64'h0000_1234_0000_0000.
- **Round-robin:** A and B both valid continuously for 6 cycles after reset, `out_ready` = 1. Expected grants A, B, A, B, A, B. `out_src` follows that order and `a_cnt` = `b_cnt` = 3.
- **Backpressure:** `out_ready` = 0 for 4 cycles with both requesters valid. Expected: `out_valid` stays 1 with `out_imm` and `out_src` unchanged, and both readies stay 0. When `out_ready` = 1, exactly one new grant is made on the same cycle.
- **Illegal format:** fmt 6 with any instr. Expected `out_imm` = 0 and `out_err` = 1; the next legal request returns `out_err` = 0.
- **Reset mid-operation:** assert `reset` asynchronously while FULL. Expected: `out_valid` drops immediately and both counters read 0. After release, the first tie is granted to A.
- **Counter saturation:** build with `CNT_W` = 4 and issue 20 A grants. Expected `a_cnt` = 4'hF.
